spi_register_bank: RTL



---
 rtl/spi_register_bank_pkg.sv | 31 +++
 rtl/spi_register_bank.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/spi_register_bank_pkg.sv
// spi_register_bank_pkg
//   Shared definitions for spi_register_bank: transaction state encoding,
//   parameter limits and the MSB-first byte selector used for read-back.
package spi_register_bank_pkg;

    localparam int unsigned MAX_REGS  = 16;
    localparam int unsigned MAX_BYTES = 4;
    localparam int unsigned MAX_BITS  = MAX_BYTES * 8;

    typedef enum logic [1:0] {
        IDLE,
        HIT,
        MISS,
        COMMIT
    } state_t;

    // Byte returned for operand index 'count' of an 'nbytes'-wide value:
    // MSB first, and the LSB repeats once the index runs past the end.
    function automatic logic [7:0] byte_select(
        input logic [MAX_BITS-1:0] value,
        input int unsigned         nbytes,
        input logic [31:0]         count
    );
        int unsigned       k;
        logic [MAX_BITS-1:0] shifted;
        k       = (count >= nbytes) ? nbytes - 1 : count;
        shifted = value >> ((nbytes - 1 - k) * 8);
        return shifted[7:0];
    endfunction

endpackage

// File: rtl/spi_register_bank.sv
// spi_register_bank
//   Bank of NUM_REGS registers, REG_BYTES wide, addressed by opcodes
//   BASE_ADDRESS .. BASE_ADDRESS+NUM_REGS-1 on the SPI peripheral clock.
//   Reads return the addressed register MSB-first; writable registers take
//   a full multi-byte write into a shadow and commit it after the
//   transaction ends.
// Ports
//   clock_in            SPI peripheral clock
//   reset_n_in          asynchronous active-low reset
//   opcode_in           transaction opcode
//   opcode_valid_in     high for the whole transaction after the opcode
//   operand_in          current operand byte
//   operand_valid_in    level, high while operand_in is valid
//   operand_count_in    index of the current operand byte
//   response_out        registered read byte
//   response_valid_out  high while this bank owns the response
//   registers_out       packed register contents, register i in slice i
//   write_strobe_out    one-cycle pulse when register i commits
module spi_register_bank #(
    parameter int unsigned                         NUM_REGS      = 4,
    parameter int unsigned                         REG_BYTES     = 2,
    parameter logic [7:0]                          BASE_ADDRESS  = 8'hE0,
    parameter logic [NUM_REGS*REG_BYTES*8-1:0]     RESET_VALUES  = '0,
    parameter logic [NUM_REGS-1:0]                 WRITABLE_MASK = '1
) (
    input  logic                               clock_in,
    input  logic                               reset_n_in,
    input  logic [7:0]                         opcode_in,
    input  logic                               opcode_valid_in,
    input  logic [7:0]                         operand_in,
    input  logic                               operand_valid_in,
    input  logic [31:0]                        operand_count_in,
    output logic [7:0]                         response_out,
    output logic                               response_valid_out,
    output logic [NUM_REGS*REG_BYTES*8-1:0]    registers_out,
    output logic [NUM_REGS-1:0]                write_strobe_out
);
    import spi_register_bank_pkg::*;

    localparam int unsigned REG_BITS = REG_BYTES * 8;
    localparam int unsigned IDX_W    = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

    // Parameter legality
    if (NUM_REGS < 1 || NUM_REGS > MAX_REGS) begin : g_bad_num_regs
        $error("spi_register_bank: NUM_REGS must be within 1..16");
    end
    if (REG_BYTES < 1 || REG_BYTES > MAX_BYTES) begin : g_bad_reg_bytes
        $error("spi_register_bank: REG_BYTES must be within 1..4");
    end
    if (int'(BASE_ADDRESS) + int'(NUM_REGS) > 256) begin : g_bad_base
        $error("spi_register_bank: opcode range exceeds 8'hFF");
    end

    state_t              r_state;
    state_t              w_next_state;
    logic [IDX_W-1:0]    r_idx;
    logic [IDX_W-1:0]    w_sel_idx;
    logic                r_opv_d;
    logic [REG_BITS-1:0] r_shadow;
    logic [REG_BYTES-1:0] r_byte_seen;
    logic [REG_BYTES-1:0] w_seen_next;
    logic [REG_BITS-1:0] r_regs [NUM_REGS];
    logic [7:0]          r_response;
    logic [NUM_REGS-1:0] r_strobe;
    logic [8:0]          w_offset;
    logic                w_hit;
    logic                w_capture;
    logic                w_pending;

    assign w_offset  = {1'b0, opcode_in} - {1'b0, BASE_ADDRESS};
    assign w_hit     = (opcode_in >= BASE_ADDRESS) && (w_offset < 9'(NUM_REGS));
    assign w_capture = (r_state == HIT) && operand_valid_in && !r_opv_d;

    // Includes a byte captured on the same edge that opcode_valid_in is seen
    // low, so the commit decision accounts for it.
    always_comb begin
        w_seen_next = r_byte_seen;
        for (int unsigned b = 0; b < REG_BYTES; b++) begin
            if (w_capture && operand_count_in == b) begin
                w_seen_next[b] = 1'b1;
            end
        end
    end

    assign w_pending = (&w_seen_next) && WRITABLE_MASK[r_idx];

    // In IDLE the register is addressed straight from the opcode so the first
    // response byte is ready in the first HIT cycle.
    assign w_sel_idx = (r_state == IDLE) ? w_offset[IDX_W-1:0] : r_idx;

    // FSM: state register
    always_ff @(posedge clock_in or negedge reset_n_in) begin
        if (!reset_n_in) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // FSM: next state
    always_comb begin
        w_next_state = r_state;
        unique case (r_state)
            IDLE: begin
                if (opcode_valid_in) begin
                    w_next_state = w_hit ? HIT : MISS;
                end
            end
            HIT: begin
                if (!opcode_valid_in) begin
                    w_next_state = w_pending ? COMMIT : IDLE;
                end
            end
            MISS: begin
                if (!opcode_valid_in) begin
                    w_next_state = IDLE;
                end
            end
            COMMIT: w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    // FSM: outputs
    always_comb begin
        response_valid_out = (r_state == HIT);
    end

    // Transaction datapath: index latch, operand capture, read byte
    always_ff @(posedge clock_in or negedge reset_n_in) begin
        if (!reset_n_in) begin
            r_idx       <= '0;
            r_opv_d     <= 1'b0;
            r_shadow    <= '0;
            r_byte_seen <= '0;
            r_response  <= '0;
        end else begin
            r_opv_d <= operand_valid_in;
            if (r_state == IDLE && w_next_state == HIT) begin
                r_idx       <= w_offset[IDX_W-1:0];
                r_byte_seen <= '0;
            end else begin
                r_byte_seen <= w_seen_next;
            end
            for (int unsigned b = 0; b < REG_BYTES; b++) begin
                if (w_capture && operand_count_in == b) begin
                    r_shadow[(REG_BYTES-1-b)*8 +: 8] <= operand_in;
                end
            end
            r_response <= (w_next_state == HIT)
                        ? byte_select(MAX_BITS'(r_regs[w_sel_idx]), REG_BYTES, operand_count_in)
                        : '0;
        end
    end

    // Commit strobe is registered alongside the register update
    always_ff @(posedge clock_in or negedge reset_n_in) begin
        if (!reset_n_in) begin
            r_strobe <= '0;
        end else if (r_state == COMMIT) begin
            r_strobe <= (NUM_REGS'(1) << r_idx) & WRITABLE_MASK;
        end else begin
            r_strobe <= '0;
        end
    end

    for (genvar i = 0; i < NUM_REGS; i++) begin : g_reg
        always_ff @(posedge clock_in or negedge reset_n_in) begin
            if (!reset_n_in) begin
                r_regs[i] <= RESET_VALUES[i*REG_BITS +: REG_BITS];
            end else if (WRITABLE_MASK[i] && r_state == COMMIT && r_idx == IDX_W'(i)) begin
                r_regs[i] <= r_shadow;
            end
        end
        assign registers_out[i*REG_BITS +: REG_BITS] = r_regs[i];
    end

    assign response_out     = r_response;
    assign write_strobe_out = r_strobe;

endmodule
